// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package sub_pkg;

  localparam int SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor_1_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with the borrow-out.
module full_subtractor_1_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor_8_bits.sv
// Bit-serial D = A - B - BIN, LSB first, one bit per clock through a single cell.
// START/BUSY/DONE handshake; D and BOUT hold until the next completed operation.
module serial_subtractor_8_bits
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] sd_shifted;

  full_subtractor_1_bit u_cell (
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  // New difference bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
  assign sd_shifted = {cell_d, sd_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    dout_d   = dout_q;
    bout_d   = bout_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sa_d     = a_i;
          sb_d     = b_i;
          borrow_d = bin_i;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        sd_d     = sd_shifted;
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        borrow_d = cell_bout;
        if (cnt_q == CNT_LAST) begin
          dout_d  = sd_shifted;
          bout_d  = cell_bout;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FINISH: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      bout_q   <= bout_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign d_o    = dout_q;
  assign bout_o = bout_q;

endmodule
